// File: rtl/ama_riscv_defines.sv
// ---------------------------------------------------------------------------
// ama_riscv_defines
//   Shared definitions for the branch-control slice of the core:
//   - pc_sel_t    : next-PC mux select encodings
//   - br_cond_t   : branch condition codes, indexed by {funct3[2], funct3[0]}
//   - BHT_CNT_INIT: reset value of every 2-bit history counter (weakly not taken)
//   - bht_cnt_next: saturating 2-bit counter update
//   - br_resolve  : branch outcome from the condition code and compare flags
// ---------------------------------------------------------------------------
package ama_riscv_defines;

  typedef enum logic [2:0] {
    PC_SEL_INC4       = 3'd0,
    PC_SEL_ALU        = 3'd1,
    PC_SEL_BP         = 3'd2,
    PC_SEL_EX_INC4    = 3'd3,
    PC_SEL_START_ADDR = 3'd4
  } pc_sel_t;

  // Unsigned variants share these codes; the comparator is told upstream.
  typedef enum logic [1:0] {
    BR_COND_EQ = 2'b00,
    BR_COND_NE = 2'b01,
    BR_COND_LT = 2'b10,
    BR_COND_GE = 2'b11
  } br_cond_t;

  localparam logic [1:0] BHT_CNT_INIT = 2'b01;

  function automatic logic [1:0] bht_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic br_resolve(input br_cond_t cond, input logic a_eq_b,
                                      input logic a_lt_b);
    case (cond)
      BR_COND_EQ: return a_eq_b;
      BR_COND_NE: return ~a_eq_b;
      BR_COND_LT: return a_lt_b;
      default:    return a_eq_b | ~a_lt_b;
    endcase
  endfunction

endpackage

// File: rtl/ama_riscv_bht.sv
// ---------------------------------------------------------------------------
// ama_riscv_bht
//   Branch history table of 2-bit saturating counters.
//   Ports:
//     clk, rst           - clock, synchronous active-high reset (all entries
//                          go to BHT_CNT_INIT)
//     rd_idx / rd_cnt    - read port (combinational)
//     upd_en / upd_idx /
//     upd_taken          - update port: increment on taken, decrement on
//                          not taken, saturating at 3 and 0
//   A read hitting the entry being updated in the same cycle returns the
//   updated value (write-first bypass).
// ---------------------------------------------------------------------------
module ama_riscv_bht
  import ama_riscv_defines::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] upd_cnt;

  assign upd_cnt = bht_cnt_next(cnt_q[upd_idx], upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_CNT_INIT;
    end else if (upd_en) begin
      cnt_q[upd_idx] <= upd_cnt;
    end
  end

  // Without the bypass a branch right behind its own resolution would see a
  // stale counter.
  assign rd_cnt = (upd_en && (upd_idx == rd_idx)) ? upd_cnt : cnt_q[rd_idx];

endmodule

// File: rtl/ama_riscv_branch_ctrl.sv
// ---------------------------------------------------------------------------
// ama_riscv_branch_ctrl
//   Next-PC selection, IF stall and pipeline flush control for the 5-stage
//   core, with an optional bimodal branch predictor.
//   Configuration macro: BRANCH_PREDICT_EN
//     defined   - BHT lookup in ID, branches predicted, mispredicts repaired
//                 from EX (ALU target or EX PC+4).
//     undefined - no BHT; IF stalls on any branch/JALR in ID, taken branches
//                 redirect to the ALU target.
//   Ports:
//     clk, rst              - clock, synchronous active-high reset
//     id_branch, id_jalr    - branch / JALR currently in ID
//     id_pc                 - PC of the ID instruction (BHT index source)
//     ex_funct3             - funct3 of the EX instruction (branch condition)
//     bc_a_eq_b, bc_a_lt_b  - branch comparator flags for the EX instruction
//     pc_sel                - next-PC mux select (see pc_sel_t)
//     pc_we                 - PC write enable
//     stall_if              - IF stall
//     clear_if, clear_id    - flush of IF/ID and ID/EX registers
//     clear_stg             - post-reset per-stage clears, bit k -> stage k+1
//     pred_taken            - ID branch predicted taken
//     mispredict            - EX branch outcome differs from its prediction
// ---------------------------------------------------------------------------
module ama_riscv_branch_ctrl
  import ama_riscv_defines::*;
#(
  parameter int PC_W          = 32,
  parameter int BHT_ENTRIES   = 16,
  parameter int RST_SEQ_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_branch,
  input  logic                     id_jalr,
  input  logic [PC_W-1:0]          id_pc,
  input  logic [2:0]               ex_funct3,
  input  logic                     bc_a_eq_b,
  input  logic                     bc_a_lt_b,
  output logic [2:0]               pc_sel,
  output logic                     pc_we,
  output logic                     stall_if,
  output logic                     clear_if,
  output logic                     clear_id,
  output logic [RST_SEQ_DEPTH-1:0] clear_stg,
  output logic                     pred_taken,
  output logic                     mispredict
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                     ex_branch;
  logic                     ex_jalr;
  logic                     ex_pred;
  logic [RST_SEQ_DEPTH-1:0] clear_stg_q;
  logic                     branch_res;
  logic                     misp_raw;
  logic                     flush;
  logic                     pred_raw;
  logic                     stall_raw;
  pc_sel_t                  pc_sel_nxt;
  logic                     unused_inputs;

  // Only the index bits of id_pc and funct3[2,0] carry meaning here.
  assign unused_inputs = ^{id_pc, ex_funct3[1]};

  assign branch_res = br_resolve(br_cond_t'({ex_funct3[2], ex_funct3[0]}),
                                 bc_a_eq_b, bc_a_lt_b);
  assign misp_raw   = ex_branch & (branch_res != ex_pred);
  assign flush      = misp_raw | ex_jalr;

  // Post-reset clear sequence: all ones in reset, then drains one bit per
  // cycle from the top so later stages are released first.
  always_ff @(posedge clk) begin
    if (rst) clear_stg_q <= '1;
    else     clear_stg_q <= clear_stg_q >> 1;
  end

  // EX-stage copies; a flush squashes whatever was in ID so a branch right
  // behind a mispredict never resolves or trains the BHT.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_branch <= 1'b0;
      ex_jalr   <= 1'b0;
      ex_pred   <= 1'b0;
    end else begin
      ex_branch <= id_branch;
      ex_jalr   <= id_jalr;
      ex_pred   <= pred_raw;
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       rd_cnt;
  logic             unused_cnt_lsb;

  assign id_idx         = id_pc[IDX_W+1:2];
  assign unused_cnt_lsb = rd_cnt[0];

  always_ff @(posedge clk) begin
    if (rst || flush) ex_idx <= '0;
    else              ex_idx <= id_idx;
  end

  ama_riscv_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (id_idx),
    .rd_cnt    (rd_cnt),
    .upd_en    (ex_branch),
    .upd_idx   (ex_idx),
    .upd_taken (branch_res)
  );

  assign pred_raw  = id_branch & rd_cnt[1];
  assign stall_raw = id_jalr & ~flush;
`else
  // Without prediction every branch is treated as not taken and IF waits
  // for it to resolve.
  assign pred_raw  = 1'b0;
  assign stall_raw = (id_branch | id_jalr) & ~flush;
`endif

  always_comb begin
    pc_sel_nxt = PC_SEL_INC4;
    if (rst || clear_stg_q[0])  pc_sel_nxt = PC_SEL_START_ADDR;
    else if (misp_raw)          pc_sel_nxt = branch_res ? PC_SEL_ALU : PC_SEL_EX_INC4;
    else if (ex_jalr)           pc_sel_nxt = PC_SEL_ALU;
    else if (pred_raw)          pc_sel_nxt = PC_SEL_BP;
  end

  // Reset is applied to the outputs directly so they hold their reset values
  // during every cycle rst is high, not only after the first edge.
  assign pc_sel     = pc_sel_nxt;
  assign clear_stg  = rst ? {RST_SEQ_DEPTH{1'b1}} : clear_stg_q;
  assign pred_taken = ~rst & pred_raw;
  assign mispredict = ~rst & misp_raw;
  assign clear_if   = ~rst & flush;
  assign clear_id   = ~rst & flush;
  assign stall_if   = ~rst & stall_raw;
  assign pc_we      = ~stall_if;

endmodule
